// File: rtl/batch_sink_if.sv
// Avalon-ST sample stream into batch_sink: valid/sop/eop qualifiers and one sample per beat.
// The source has no ready input, so the sink can never apply backpressure.
interface batch_sink_if #(
  parameter int DATA_WIDTH = 14
);
  logic                  sink_valid;
  logic                  sink_sop;
  logic                  sink_eop;
  logic [DATA_WIDTH-1:0] sink_data;

  modport master (output sink_valid, output sink_sop, output sink_eop, output sink_data);
  modport slave  (input  sink_valid, input  sink_sop, input  sink_eop, input  sink_data);
endinterface

// File: rtl/batch_sink.sv
// Framing-checked Avalon-ST batch sink that fills a two-bank ping-pong RAM.
// A completed bank is offered to the consumer through a registered random-access read port.
module batch_sink #(
  parameter  int DATA_WIDTH = 14,
  parameter  int BATCH_SIZE = 2048,
  parameter  int RUNS       = 3,
  localparam int AW         = $clog2(BATCH_SIZE)
) (
  input  logic                  sink_clk,
  input  logic                  reset,
  batch_sink_if.slave           sink,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  batch_ready,
  input  logic                  batch_release,
  output logic [15:0]           batch_count,
  output logic                  err_framing,
  output logic                  err_overflow,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DROP,
    S_DONE
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(BATCH_SIZE - 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  ready_q, ready_d;
  logic [1:0]            full_q, full_d;
  logic [15:0]           count_q, count_d;
  logic                  ferr_q, ferr_d;
  logic                  oerr_q, oerr_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  we;
  logic [AW-1:0]         w_idx;
  logic                  commit;
  logic [1:0]            full_rel;
  logic                  ready_rel;
  logic                  rd_bank_rel;

  logic [DATA_WIDTH-1:0] mem [2*BATCH_SIZE];

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q;
    count_d   = count_q;
    ferr_d    = 1'b0;
    oerr_d    = 1'b0;
    done_d    = done_q;
    we        = 1'b0;
    w_idx     = cnt_q;
    commit    = 1'b0;

    // A release is applied before any commit in the same cycle, so a committing bank can take over at once.
    full_rel    = full_q;
    ready_rel   = ready_q;
    rd_bank_rel = rd_bank_q;
    if (batch_release && ready_q) begin
      full_rel[rd_bank_q] = 1'b0;
      if (full_q[!rd_bank_q]) rd_bank_rel = !rd_bank_q;
      else                    ready_rel   = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (sink.sink_valid) begin
          if (!sink.sink_sop) begin
            ferr_d = 1'b1;
          end else if (!full_rel[0] || !full_rel[1]) begin
            wr_bank_d = full_rel[0];
            we        = 1'b1;
            w_idx     = '0;
            cnt_d     = AW'(1);
            state_d   = S_RECV;
          end else begin
            oerr_d  = 1'b1;
            state_d = S_DROP;
          end
        end
      end
      S_RECV: begin
        if (sink.sink_valid) begin
          if (sink.sink_sop) begin
            ferr_d = 1'b1;
            we     = 1'b1;
            w_idx  = '0;
            cnt_d  = AW'(1);
          end else if (cnt_q == LAST_IDX) begin
            if (sink.sink_eop) begin
              we     = 1'b1;
              commit = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
            cnt_d   = '0;
            state_d = S_IDLE;
          end else if (sink.sink_eop) begin
            ferr_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            we    = 1'b1;
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      S_DROP: begin
        if (sink.sink_valid && sink.sink_eop) state_d = S_IDLE;
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase

    full_d    = full_rel;
    ready_d   = ready_rel;
    rd_bank_d = rd_bank_rel;
    if (commit) begin
      full_d[wr_bank_q] = 1'b1;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      if (!ready_rel) begin
        rd_bank_d = wr_bank_q;
        ready_d   = 1'b1;
      end
      if (RUNS > 0 && count_d == 16'(RUNS)) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sink_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      ready_q   <= 1'b0;
      full_q    <= '0;
      count_q   <= '0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      ready_q   <= ready_d;
      full_q    <= full_d;
      count_q   <= count_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
      done_q    <= done_d;
      rd_data_q <= mem[{rd_bank_q, rd_addr}];
    end
  end

  // NOTE: the sample RAM has no reset; bank contents only matter once the bank is marked full.
  always_ff @(posedge sink_clk) begin
    if (we) mem[{wr_bank_d, w_idx}] <= sink.sink_data;
  end

  assign rd_data      = rd_data_q;
  assign batch_ready  = ready_q;
  assign batch_count  = count_q;
  assign err_framing  = ferr_q;
  assign err_overflow = oerr_q;
  assign done         = done_q;

endmodule

// File: tb/tb_batch_sink.sv
// Directed bench for batch_sink: a framing-scenario table plus hand-written multi-cycle sequences.
// Expected values are hand-derived from packet length, data base and release timing.
module tb_batch_sink;
  localparam int DW = 14;
  localparam int N  = 2048;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          batch_ready;
  logic          batch_release = 1'b0;
  logic [15:0]   batch_count;
  logic          err_framing;
  logic          err_overflow;
  logic          done;

  int checks = 0;
  int failures = 0;
  int n_ferr = 0;
  int n_oerr = 0;

  batch_sink_if #(.DATA_WIDTH(DW)) sif ();

  batch_sink #(.DATA_WIDTH(DW), .BATCH_SIZE(N), .RUNS(3)) dut (
    .sink_clk      (clk),
    .reset         (reset),
    .sink          (sif.slave),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .batch_ready   (batch_ready),
    .batch_release (batch_release),
    .batch_count   (batch_count),
    .err_framing   (err_framing),
    .err_overflow  (err_overflow),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    len;
    int    sop_at;
    int    eop_at;
    int    exp_ferr;
    int    exp_count;
    logic  exp_ready;
    int    exp_rd5;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: inputs driven at negedge, outputs sampled 1 time unit after the rising edge.
  task automatic step(input logic v, input logic sop, input logic eop, input int d, input logic rel);
    @(negedge clk);
    sif.sink_valid = v;
    sif.sink_sop   = sop;
    sif.sink_eop   = eop;
    sif.sink_data  = DW'(d);
    batch_release  = rel;
    @(posedge clk);
    #1;
    n_ferr += int'(err_framing);
    n_oerr += int'(err_overflow);
    sif.sink_valid = 1'b0;
    sif.sink_sop   = 1'b0;
    sif.sink_eop   = 1'b0;
    batch_release  = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int sop_at, input int eop_at, input int base, input int rel_at);
    for (int i = 0; i < len; i++)
      step(1'b1, (i == 0) || (i == sop_at), i == eop_at, base + i, i == rel_at);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sif.sink_valid = 1'b0;
    sif.sink_sop   = 1'b0;
    sif.sink_eop   = 1'b0;
    batch_release  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    n_ferr = 0;
    n_oerr = 0;
  endtask

  task automatic read_at(input int addr, output int val);
    @(negedge clk);
    rd_addr = AW'(addr);
    @(posedge clk);
    #1;
    val = int'(rd_data);
  endtask

  initial begin
    int v;
    sif.sink_valid = 1'b0;
    sif.sink_sop   = 1'b0;
    sif.sink_eop   = 1'b0;
    sif.sink_data  = '0;

    tbl[0] = '{"clean",       N,      -1, N - 1,  0, 1, 1'b1, 5};
    tbl[1] = '{"early_eop",   101,    -1, 100,    1, 0, 1'b0, 0};
    tbl[2] = '{"missing_eop", N,      -1, -1,     1, 0, 1'b0, 0};
    tbl[3] = '{"resop_50",    N + 50, 50, N + 49, 1, 1, 1'b1, 55};
    tbl[4] = '{"overlong",    N + 1,  -1, N,      2, 0, 1'b0, 0};

    // Reset state and a single clean packet.
    do_reset();
    check("rst_ready", int'(batch_ready), 0);
    check("rst_count", int'(batch_count), 0);
    check("rst_ferr", int'(err_framing), 0);
    check("rst_oerr", int'(err_overflow), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_data", int'(rd_data), 0);
    send_pkt(N - 1, -1, -1, 0, -1);
    check("t1_ready_before_eop", int'(batch_ready), 0);
    step(1'b1, 1'b0, 1'b1, N - 1, 1'b0);
    check("t1_ready_after_eop", int'(batch_ready), 1);
    check("t1_count", int'(batch_count), 1);
    check("t1_ferr", n_ferr, 0);
    foreach (tbl[i]) begin
      int k;
      k = (i * 511) % N;
      read_at(k, v);
      check("t1_rd", v, k);
    end
    read_at(N - 1, v);
    check("t1_rd_last", v, N - 1);

    // Two packets queued, overflow on a third, then releases drain in order.
    do_reset();
    send_pkt(N, -1, N - 1, 0, -1);
    send_pkt(N, -1, N - 1, 1000, -1);
    check("t2_count", int'(batch_count), 2);
    check("t2_ready", int'(batch_ready), 1);
    send_pkt(N, -1, N - 1, 2000, -1);
    check("t3_oerr_pulses", n_oerr, 1);
    check("t3_ferr", n_ferr, 0);
    check("t3_count", int'(batch_count), 2);
    read_at(5, v);
    check("t2_rd_first", v, 5);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    check("t2_ready_after_rel1", int'(batch_ready), 1);
    read_at(5, v);
    check("t2_rd_second", v, 1005);
    read_at(N - 1, v);
    check("t2_rd_second_last", v, 1000 + N - 1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    check("t2_ready_after_rel2", int'(batch_ready), 0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    check("t2_stray_release", int'(batch_ready), 0);
    check("t2_count_final", int'(batch_count), 2);

    // Framing-error scenarios, each from a fresh reset.
    foreach (tbl[i]) begin
      do_reset();
      send_pkt(tbl[i].len, tbl[i].sop_at, tbl[i].eop_at, 0, -1);
      check({tbl[i].name, "_ferr"}, n_ferr, tbl[i].exp_ferr);
      check({tbl[i].name, "_oerr"}, n_oerr, 0);
      check({tbl[i].name, "_count"}, int'(batch_count), tbl[i].exp_count);
      check({tbl[i].name, "_ready"}, int'(batch_ready), int'(tbl[i].exp_ready));
      if (tbl[i].exp_ready) begin
        read_at(5, v);
        check({tbl[i].name, "_rd5"}, v, tbl[i].exp_rd5);
      end
    end

    // Beat without sop while idle: exactly one single-cycle framing pulse.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 7, 1'b0);
    check("idle_nosop_pulse", int'(err_framing), 1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    check("idle_nosop_clear", int'(err_framing), 0);

    // Release on the same cycle as a commit: the new bank becomes readable at once.
    do_reset();
    send_pkt(N, -1, N - 1, 0, -1);
    send_pkt(N, -1, N - 1, 3000, N - 1);
    check("same_cyc_ready", int'(batch_ready), 1);
    check("same_cyc_count", int'(batch_count), 2);
    check("same_cyc_oerr", n_oerr, 0);
    read_at(5, v);
    check("same_cyc_rd", v, 3005);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    check("same_cyc_drained", int'(batch_ready), 0);

    // RUNS=3: done after the third commit, later packets ignored.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      send_pkt(N, -1, N - 1, 100 * p, -1);
      step(1'b0, 1'b0, 1'b0, 0, 1'b1);
      if (p == 1) check("runs_done_early", int'(done), 0);
      if (p == 2) begin
        check("runs_done", int'(done), 1);
        check("runs_count3", int'(batch_count), 3);
      end
    end
    check("runs_count_final", int'(batch_count), 3);
    check("runs_done_sticky", int'(done), 1);
    check("runs_ready", int'(batch_ready), 0);
    check("runs_ferr", n_ferr, 0);

    // Reset in the middle of a packet discards it.
    do_reset();
    send_pkt(1000, -1, -1, 0, -1);
    do_reset();
    send_pkt(N, -1, N - 1, 4000, -1);
    check("midrst_count", int'(batch_count), 1);
    check("midrst_ready", int'(batch_ready), 1);
    check("midrst_ferr", n_ferr, 0);
    read_at(5, v);
    check("midrst_rd", v, 4005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
